hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_fwd_ctrl_if.sv | 40 ++++
 rtl/hazard_fwd_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// Hazard/forwarding control bus.
// Groups the ID-stage instruction fields and the flush request (driven by the
// pipeline front end) with the hazard flags, EX result select, stall request
// and performance counters returned by hazard_fwd_ctrl.
//   master : pipeline side   (drives id_*, flush; receives flags/stall/counters)
//   slave  : hazard_fwd_ctrl (receives id_*, flush; drives flags/stall/counters)
interface hazard_fwd_ctrl_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic [AW-1:0] id_AA;
  logic [AW-1:0] id_BA;
  logic [AW-1:0] id_DA;
  logic          id_RW;
  logic [1:0]    id_MD;
  logic          id_MA;
  logic          id_MB;
  logic          flush;

  logic          EX_Hazard_A;
  logic          WB_Hazard_A;
  logic          EX_Hazard_B;
  logic          WB_Hazard_B;
  logic [1:0]    EX_MD;
  logic          stall;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  modport master (
    output id_AA, id_BA, id_DA, id_RW, id_MD, id_MA, id_MB, flush,
    input  EX_Hazard_A, WB_Hazard_A, EX_Hazard_B, WB_Hazard_B,
           EX_MD, stall, stall_cnt, bubble_cnt
  );

  modport slave (
    input  id_AA, id_BA, id_DA, id_RW, id_MD, id_MA, id_MB, flush,
    output EX_Hazard_A, WB_Hazard_A, EX_Hazard_B, WB_Hazard_B,
           EX_MD, stall, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control at the ID->EX boundary.
// Tracks the destination register of the instructions in EX and WB, compares
// them with the ID source registers, and registers EX/WB forwarding flags for
// the operand muxes in EX. A load in EX feeding the ID instruction raises a
// one-cycle stall and a bubble is injected into EX. A flush also injects a
// bubble and overrides the stall.
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset
//   bus   : hazard_fwd_ctrl_if.slave (ID fields, flush in; flags, EX_MD,
//           stall, stall_cnt, bubble_cnt out)
module hazard_fwd_ctrl #(
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  localparam logic [1:0] MD_LOAD = 2'b01;

  // EX and WB tracking slots
  logic [AW-1:0] r_ex_da;
  logic          r_ex_rw;
  logic [1:0]    r_ex_md;
  logic [AW-1:0] r_wb_da;
  logic          r_wb_rw;

  logic          r_ex_haz_a;
  logic          r_wb_haz_a;
  logic          r_ex_haz_b;
  logic          r_wb_haz_b;
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_bubble_cnt;

  logic w_ex_a;
  logic w_wb_a;
  logic w_ex_b;
  logic w_wb_b;
  logic w_stall;
  logic w_bubble;

  // Register 0 is hard-wired zero, so a write to it never creates a dependency.
  assign w_ex_a = (bus.id_AA == r_ex_da) && r_ex_rw && (r_ex_da != '0) && !bus.id_MA;
  assign w_wb_a = (bus.id_AA == r_wb_da) && r_wb_rw && (r_wb_da != '0) && !bus.id_MA;
  assign w_ex_b = (bus.id_BA == r_ex_da) && r_ex_rw && (r_ex_da != '0) && !bus.id_MB;
  assign w_wb_b = (bus.id_BA == r_wb_da) && r_wb_rw && (r_wb_da != '0) && !bus.id_MB;

  // A squashed ID instruction cannot consume the load, so flush masks stall.
  assign w_stall  = (w_ex_a || w_ex_b) && (r_ex_md == MD_LOAD) && !bus.flush;
  assign w_bubble = w_stall || bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_da    <= '0;
      r_ex_rw    <= 1'b0;
      r_ex_md    <= 2'b00;
      r_wb_da    <= '0;
      r_wb_rw    <= 1'b0;
      r_ex_haz_a <= 1'b0;
      r_wb_haz_a <= 1'b0;
      r_ex_haz_b <= 1'b0;
      r_wb_haz_b <= 1'b0;
    end else begin
      r_wb_da <= r_ex_da;
      r_wb_rw <= r_ex_rw;
      if (w_bubble) begin
        r_ex_da    <= '0;
        r_ex_rw    <= 1'b0;
        r_ex_md    <= 2'b00;
        r_ex_haz_a <= 1'b0;
        r_wb_haz_a <= 1'b0;
        r_ex_haz_b <= 1'b0;
        r_wb_haz_b <= 1'b0;
      end else begin
        r_ex_da    <= bus.id_DA;
        r_ex_rw    <= bus.id_RW;
        r_ex_md    <= bus.id_MD;
        r_ex_haz_a <= w_ex_a;
        r_wb_haz_a <= w_wb_a;
        r_ex_haz_b <= w_ex_b;
        r_wb_haz_b <= w_wb_b;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

  assign bus.EX_Hazard_A = r_ex_haz_a;
  assign bus.WB_Hazard_A = r_wb_haz_a;
  assign bus.EX_Hazard_B = r_ex_haz_b;
  assign bus.WB_Hazard_B = r_wb_haz_b;
  assign bus.EX_MD       = r_ex_md;
  assign bus.stall       = w_stall;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios followed by random traffic,
// all checked against a pipeline-history model (queue of issued instructions).
module tb_hazard_fwd_ctrl;

  localparam int AW  = 5;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [AW-1:0] da;
    logic          rw;
    logic [1:0]    md;
  } slot_t;

  logic clk;
  logic rst_n;

  hazard_fwd_ctrl_if #(.AW(AW), .CW(CW)) bus ();

  hazard_fwd_ctrl #(.AW(AW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pipe[0] is the instruction now in EX, pipe[1] the one in WB.
  slot_t pipe[$];
  logic  m_exa, m_wba, m_exb, m_wbb;
  int    m_stall_cnt, m_bubble_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic depends(input slot_t s, input logic [AW-1:0] src, input logic not_read);
    return !not_read && s.rw && (s.da != 0) && (s.da == src);
  endfunction

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(slot_t'(0));
    pipe.push_back(slot_t'(0));
    m_exa = 0; m_wba = 0; m_exb = 0; m_wbb = 0;
    m_stall_cnt = 0;
    m_bubble_cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ":EX_Hazard_A"}, 32'(bus.EX_Hazard_A), 32'(m_exa));
    chk({tag, ":WB_Hazard_A"}, 32'(bus.WB_Hazard_A), 32'(m_wba));
    chk({tag, ":EX_Hazard_B"}, 32'(bus.EX_Hazard_B), 32'(m_exb));
    chk({tag, ":WB_Hazard_B"}, 32'(bus.WB_Hazard_B), 32'(m_wbb));
    chk({tag, ":EX_MD"},       32'(bus.EX_MD),       32'(pipe[0].md));
    chk({tag, ":stall_cnt"},   32'(bus.stall_cnt),   32'(m_stall_cnt));
    chk({tag, ":bubble_cnt"},  32'(bus.bubble_cnt),  32'(m_bubble_cnt));
  endtask

  task automatic drive(input logic [AW-1:0] aa, ba, da, input logic rw,
                       input logic [1:0] md, input logic ma, mb, fl);
    bus.id_AA = aa; bus.id_BA = ba; bus.id_DA = da; bus.id_RW = rw;
    bus.id_MD = md; bus.id_MA = ma; bus.id_MB = mb; bus.flush = fl;
  endtask

  // Present one ID instruction for one cycle, check at negedge, advance model.
  task automatic step(input string tag, input logic [AW-1:0] aa, ba, da, input logic rw,
                      input logic [1:0] md, input logic ma, mb, fl);
    logic ea, wa, eb, wb, st;
    slot_t nxt;
    drive(aa, ba, da, rw, md, ma, mb, fl);
    @(negedge clk);
    ea = depends(pipe[0], aa, ma);
    wa = depends(pipe[1], aa, ma);
    eb = depends(pipe[0], ba, mb);
    wb = depends(pipe[1], ba, mb);
    st = (ea || eb) && (pipe[0].md == 2'b01) && !fl;
    chk({tag, ":stall"}, 32'(bus.stall), 32'(st));
    check_regs(tag);
    if (st || fl) begin
      nxt = slot_t'(0);
      {m_exa, m_wba, m_exb, m_wbb} = 4'b0000;
      if (m_bubble_cnt < SAT) m_bubble_cnt++;
    end else begin
      nxt = '{da: da, rw: rw, md: md};
      {m_exa, m_wba, m_exb, m_wbb} = {ea, wa, eb, wb};
    end
    if (st && m_stall_cnt < SAT) m_stall_cnt++;
    pipe.push_front(nxt);
    void'(pipe.pop_back());
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset:stall", 32'(bus.stall), 32'd0);
    check_regs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle, nothing writes
    for (int i = 0; i < 3; i++) step("idle", 5'd3, 5'd4, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // ALU back-to-back: R3 writer, then A reads R3, then B reads R3
    step("alu_w3", 5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step("alu_a3", 5'd3, 5'd9, 5'd10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("alu:EX_Hazard_A_set", 32'(bus.EX_Hazard_A), 32'd1);
    step("alu_b3", 5'd9, 5'd3, 5'd11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("alu:WB_Hazard_B_set", 32'(bus.WB_Hazard_B), 32'd1);
    chk("alu:EX_Hazard_B_clr", 32'(bus.EX_Hazard_B), 32'd0);
    step("alu_idle", 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Load-use: load R5, dependent instruction held one extra cycle
    step("ld_w5", 5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("ld_use", 5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("ld:EX_MD_bubble", 32'(bus.EX_MD), 32'd0);
    chk("ld:stall_cnt", 32'(bus.stall_cnt), 32'd1);
    step("ld_held", 5'd5, 5'd1, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("ld:WB_Hazard_A_set", 32'(bus.WB_Hazard_A), 32'd1);
    chk("ld:EX_Hazard_A_clr", 32'(bus.EX_Hazard_A), 32'd0);

    // Masking: R0 writer; R7 writer read through PC / immediate operands
    step("m_w0", 5'd1, 5'd2, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step("m_r0", 5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step("m_ma", 5'd7, 5'd7, 5'd8, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("mask:EX_Hazard_A", 32'(bus.EX_Hazard_A), 32'd0);
    chk("mask:EX_Hazard_B", 32'(bus.EX_Hazard_B), 32'd0);

    // Flush during a load-use condition
    step("fl_ld", 5'd1, 5'd2, 5'd9, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    step("fl_use", 5'd9, 5'd9, 5'd4, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    step("fl_after", 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Reset asserted in the middle of a stall cycle
    step("rs_ld", 5'd1, 5'd2, 5'd12, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    drive(5'd12, 5'd0, 5'd13, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid:stall_before", 32'(bus.stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid:stall", 32'(bus.stall), 32'd0);
    check_regs("rst_mid");
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("rst_rel", 5'd12, 5'd0, 5'd13, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step("rst_rel2", 5'd13, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Random traffic over a small register set to provoke frequent hazards
    for (int i = 0; i < 400; i++) begin
      logic [1:0] md_r;
      md_r = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      step("rand",
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), md_r,
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    // Self-dependent load repeated: a stall every other cycle, > 2^CW+3 stalls
    for (int i = 0; i < 2 * (SAT + 4) + 4; i++)
      step("sat", 5'd5, 5'd0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("sat:stall_cnt", 32'(bus.stall_cnt), 32'(SAT));
    chk("sat:bubble_cnt", 32'(bus.bubble_cnt), 32'(SAT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
